// File: rtl/fir_stim_gen.sv
// fir_stim_gen: valid/ready stimulus source (impulse/step/ramp/square + zero flush); FIR_STIM_PRBS_EN makes mode 11 a PRBS sign
module fir_stim_gen #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int STEP      = 2,
  parameter int FLUSH_LEN = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] amp,
  input  logic [LEN_W-1:0]  count,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid,
  input  logic              x_ready,
  output logic              busy,
  output logic              done
);
  localparam int FW = $clog2(FLUSH_LEN + 2);
  localparam int RW = DATA_W + LEN_W;
  localparam logic [RW-1:0] MAXV = (RW'(1) << (DATA_W - 1)) - RW'(1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] mode_r;
  logic [DATA_W-2:0] mag, smag;
  logic [LEN_W-1:0] len, n;
  logic [FW-1:0] fcnt;
  logic [RW-1:0] ramp;
  logic active, xfer, accept, last_run, last_flush, neg, unused_amp_msb;
  assign unused_amp_msb = amp[DATA_W-1];
  assign active = state == RUN || state == FLUSH;
  assign x_valid = active;
  assign busy = active;
  assign done = state == DONE;
  assign xfer = active && x_ready;
  assign accept = state == IDLE && start;
  assign last_run = n == len - 1'b1;
  assign last_flush = fcnt == FW'(FLUSH_LEN - 1);
  assign ramp = RW'(mag) + RW'(n) * RW'(STEP);
  // state register
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: RUN and FLUSH only advance on a transfer, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (start) begin
          if (count != '0) state_nxt = RUN;
          else if (FLUSH_LEN != 0) state_nxt = FLUSH;
          else state_nxt = DONE;
        end
      RUN:
        if (xfer && last_run) begin
          if (FLUSH_LEN != 0) state_nxt = FLUSH;
          else state_nxt = DONE;
        end
      FLUSH:
        if (xfer && last_flush) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // capture the command on start; sample and flush indices step per transfer
  always_ff @(posedge clk)
    if (!reset) begin
      mode_r <= '0;
      mag <= '0;
      len <= '0;
      n <= '0;
      fcnt <= '0;
    end else if (accept) begin
      mode_r <= mode;
      mag <= amp[DATA_W-2:0];
      len <= count;
      n <= '0;
      fcnt <= '0;
    end else if (xfer) begin
      if (state == RUN) n <= n + 1'b1;
      else fcnt <= fcnt + 1'b1;
    end
`ifdef FIR_STIM_PRBS_EN
  logic [15:0] lfsr;
  // right-shifting Fibonacci LFSR (taps 16,14,13,11), bit 0 gives the sign of the current sample
  always_ff @(posedge clk)
    if (!reset) lfsr <= '0;
    else if (accept) lfsr <= 16'hACE1;
    else if (xfer && state == RUN) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
  // magnitude and sign for the current index; ramp clamps so negation never hits the most-negative value
  always_comb begin
    smag = mag;
    neg = 1'b0;
    if (mode_r == 2'b00) smag = n == '0 ? mag : '0;
    else if (mode_r == 2'b10) begin
      smag = ramp > MAXV ? MAXV[DATA_W-2:0] : ramp[DATA_W-2:0];
      neg = n[0];
    end else if (mode_r == 2'b11) begin
`ifdef FIR_STIM_PRBS_EN
      neg = lfsr[0];
`else
      neg = n[0];
`endif
    end
  end
  assign x_out = state == RUN ? (neg ? -{1'b0, smag} : {1'b0, smag}) : '0;
endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: scoreboard bench for fir_stim_gen (honours FIR_STIM_PRBS_EN)
module tb_fir_stim_gen;
  localparam int FLUSH_LEN = 11;
  logic clk = 0, reset = 0, start = 0, x_ready = 1;
  logic [1:0] mode = 0;
  logic [31:0] amp = 0;
  logic [7:0] count = 0;
  logic [31:0] x_out;
  logic x_valid, busy, done;
  logic [31:0] q[$];
  int pass = 0, total = 0;
  bit stall_prev = 0;
  logic [31:0] last_x = 0;

  fir_stim_gen #(.DATA_W(32), .LEN_W(8), .STEP(2), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amp(amp), .count(count),
    .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
  endtask

  function automatic logic [31:0] model(input int m, input logic [31:0] a, input int n, input logic [15:0] l);
    longint mg, v;
    mg = longint'(a[30:0]);
    if (m == 0) v = (n == 0) ? mg : 0;
    else if (m == 1) v = mg;
    else if (m == 2) begin
      v = mg + longint'(n) * 2;
      if (v > 64'sd2147483647) v = 64'sd2147483647;
      if (n % 2 == 1) v = -v;
    end else begin
`ifdef FIR_STIM_PRBS_EN
      v = l[0] ? -mg : mg;
`else
      v = (n % 2 == 1) ? -mg : mg;
`endif
    end
    return v[31:0];
  endfunction

  // transfers pop the scoreboard; a stalled sample must hold
  always @(negedge clk) if (reset) begin
    if (stall_prev) begin
      chk("hold_value", x_out, last_x);
      chk("hold_valid", {31'b0, x_valid}, 32'd1);
    end
    if (x_valid && x_ready) begin
      if (q.size() == 0) chk("extra_sample", {31'b0, x_valid}, 32'd0);
      else chk("sample", x_out, q.pop_front());
    end
    stall_prev = x_valid && !x_ready;
    last_x = x_out;
  end

  task automatic run_seq(input int m, input logic [31:0] a, input int c, input bit tog, input bit rogue, input int exp_busy);
    logic [15:0] l;
    int busy_n;
    bit got_done;
    l = 16'hACE1;
    for (int n = 0; n < c; n++) begin
      q.push_back(model(m, a, n, l));
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    repeat (FLUSH_LEN) q.push_back(32'd0);
    @(posedge clk) #1;
    mode = m[1:0]; amp = a; count = c[7:0]; start = 1; x_ready = 1;
    @(posedge clk) #1;
    start = 0; mode = 2'b01; amp = 32'hFFFF_FFFF; count = 8'hFF;
    busy_n = 0;
    got_done = 0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        got_done = 1;
        chk("done_no_valid", {31'b0, x_valid}, 32'd0);
        chk("done_no_busy", {31'b0, busy}, 32'd0);
      end
      @(posedge clk) #1;
      if (tog) x_ready = ~x_ready;
      if (rogue) start = (i == 3);
    end
    start = 0;
    x_ready = 1;
    chk("done_seen", {31'b0, got_done}, 32'd1);
    if (exp_busy >= 0) chk("busy_cycles", busy_n, exp_busy);
    chk("queue_empty", q.size(), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_after", {31'b0, busy}, 32'd0);
    q.delete();
  endtask

  initial begin
    reset = 0; start = 1; mode = 2; amp = 9; count = 5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", {31'b0, x_valid}, 32'd0);
      chk("rst_xout", x_out, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
    end
    @(posedge clk) #1;
    reset = 1; start = 0;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_valid", {31'b0, x_valid}, 32'd0);
    run_seq(2, 32'd3, 11, 0, 0, 22);
    run_seq(0, 32'd100, 4, 1, 0, -1);
    run_seq(2, 32'h7FFF_FFFE, 3, 0, 0, 14);
    run_seq(1, 32'd77, 0, 0, 1, 11);
    repeat (5) begin
      @(negedge clk);
      chk("no_restart", {31'b0, x_valid}, 32'd0);
    end
    run_seq(3, 32'd5, 8, 0, 0, 19);
    run_seq(3, 32'h8000_0005, 8, 1, 0, -1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
